// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_arb_pkg
// Purpose: Shared types and helpers for the SPI configuration arbiter:
//          FSM state encoding, channel-index width, round-robin pick.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  localparam int CH_IDX_W = 3;

  // First set bit of req searching upward from ptr+1, wrapping modulo n.
  // ptr < n <= 8, so ptr+i < 2n and one conditional subtract is a full modulo.
  function automatic logic [CH_IDX_W-1:0] rr_pick(input logic [7:0]          req,
                                                  input logic [CH_IDX_W-1:0] ptr,
                                                  input int                  n);
    logic [CH_IDX_W-1:0] pick;
    logic                found;
    logic [4:0]          sum;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      sum = 5'(ptr) + 5'(i);
      if (sum >= 5'(n)) sum = sum - 5'(n);
      if ((i <= n) && !found && req[sum[CH_IDX_W-1:0]]) begin
        pick  = sum[CH_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Purpose: Combinational round-robin pick of the next channel index from an
//          eligibility mask and the last-granted pointer.
// Ports  : eligible_i  NUM_CH     channels allowed to win
//          ptr_i       CH_IDX_W   last granted index (search starts at +1)
//          valid_o     1          some channel is eligible
//          idx_o       CH_IDX_W   winning index (valid only with valid_o)
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0]   eligible_i,
  input  logic [CH_IDX_W-1:0] ptr_i,
  output logic                valid_o,
  output logic [CH_IDX_W-1:0] idx_o
);

  logic [7:0] w_req_ext;

  always_comb begin
    w_req_ext               = '0;
    w_req_ext[NUM_CH-1:0]   = eligible_i;
  end

  assign valid_o = |eligible_i;
  assign idx_o   = rr_pick(w_req_ext, ptr_i, NUM_CH);

endmodule
`default_nettype wire

// File: rtl/spi_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module : spi_cfg_arbiter
// Purpose: Round-robin, session-locked arbiter between NUM_CH configuration
//          masters and one shared spi_master. Routes chip select per device,
//          returns busy/read data, force-releases sessions that overrun.
// Ports  : clk_20m, rstn (sync, active low)
//          req_i/wr_cmd_i/rd_cmd_i/wr_data_i  per-channel requests/commands
//          busy_o, grant_o, dev_cs_n_o        per-channel status/routing
//          rd_data_o                          broadcast read data
//          spi_*_o / spi_*_i                  shared spi_master interface
//          timeout_clr_i, timeout_o, timeout_ch_o  session-timeout reporting
// Rev    : 1.0  initial release
// ============================================================================
module spi_cfg_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int MOSI_W      = 24,
  parameter int MISO_W      = 8,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                     clk_20m,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        wr_cmd_i,
  input  logic [NUM_CH-1:0]        rd_cmd_i,
  input  logic [NUM_CH*MOSI_W-1:0] wr_data_i,
  output logic [NUM_CH-1:0]        busy_o,
  output logic [MISO_W:0]          rd_data_o,
  output logic [NUM_CH-1:0]        grant_o,
  output logic                     spi_wr_cmd_o,
  output logic                     spi_rd_cmd_o,
  output logic [MOSI_W-1:0]        spi_wr_data_o,
  input  logic                     spi_busy_i,
  input  logic                     spi_ncs_i,
  input  logic [MISO_W:0]          spi_rd_data_i,
  output logic [NUM_CH-1:0]        dev_cs_n_o,
  input  logic                     timeout_clr_i,
  output logic                     timeout_o,
  output logic [CH_IDX_W-1:0]      timeout_ch_o
);

  localparam int                 C_TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT_CYC - 1);

  arb_state_e            state_q,      state_d;
  logic [NUM_CH-1:0]     grant_q,      grant_d;
  logic [CH_IDX_W-1:0]   gidx_q,       gidx_d;
  logic [CH_IDX_W-1:0]   ptr_q,        ptr_d;
  logic [C_TMR_W-1:0]    timer_q,      timer_d;
  logic                  wr_cmd_q,     wr_cmd_d;
  logic                  rd_cmd_q,     rd_cmd_d;
  logic [MOSI_W-1:0]     wr_data_q,    wr_data_d;
  logic                  pend_q,       pend_d;
  logic [NUM_CH-1:0]     blocked_q,    blocked_d;
  logic                  timeout_q,    timeout_d;
  logic [CH_IDX_W-1:0]   timeout_ch_q, timeout_ch_d;

  logic                  w_pick_valid;
  logic [CH_IDX_W-1:0]   w_pick_idx;
  logic                  w_req_g;
  logic                  w_wr_g;
  logic                  w_rd_g;
  logic [MOSI_W-1:0]     w_data_g;
  logic                  w_cmd_out;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .eligible_i (req_i & ~blocked_q),
    .ptr_i      (ptr_q),
    .valid_o    (w_pick_valid),
    .idx_o      (w_pick_idx)
  );

  // grant_q is one-hot, so masking by it selects the granted channel.
  assign w_req_g   = |(req_i    & grant_q);
  assign w_wr_g    = |(wr_cmd_i & grant_q);
  assign w_rd_g    = |(rd_cmd_i & grant_q);
  assign w_cmd_out = wr_cmd_q | rd_cmd_q;

  always_comb begin
    w_data_g = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_q[k]) w_data_g = w_data_g | wr_data_i[k*MOSI_W +: MOSI_W];
    end
  end

  // State register
  always_ff @(posedge clk_20m) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      ptr_q        <= CH_IDX_W'(NUM_CH - 1);
      timer_q      <= '0;
      wr_cmd_q     <= 1'b0;
      rd_cmd_q     <= 1'b0;
      wr_data_q    <= '0;
      pend_q       <= 1'b0;
      blocked_q    <= '0;
      timeout_q    <= 1'b0;
      timeout_ch_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      ptr_q        <= ptr_d;
      timer_q      <= timer_d;
      wr_cmd_q     <= wr_cmd_d;
      rd_cmd_q     <= rd_cmd_d;
      wr_data_q    <= wr_data_d;
      pend_q       <= pend_d;
      blocked_q    <= blocked_d;
      timeout_q    <= timeout_d;
      timeout_ch_q <= timeout_ch_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    wr_cmd_d     = 1'b0;
    rd_cmd_d     = 1'b0;
    wr_data_d    = wr_data_q;
    timeout_ch_d = timeout_ch_q;
    // A timed-out channel stays blocked only while it keeps requesting.
    blocked_d    = blocked_q & req_i;
    // Clear request first so a same-cycle timeout below overrides it.
    timeout_d    = timeout_q & ~timeout_clr_i;
    // Busy seen while the command strobe is still out belongs to a
    // previous transfer, so only clear once the strobe has gone.
    pend_d       = pend_q;
    if (spi_busy_i && !w_cmd_out) pend_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_pick_valid) begin
          state_d = ST_GRANT;
          grant_d = NUM_CH'(1) << w_pick_idx;
          gidx_d  = w_pick_idx;
          ptr_d   = w_pick_idx;
          timer_d = '0;
        end
      end
      ST_GRANT: begin
        timer_d = timer_q + C_TMR_W'(1);
        if (w_wr_g) begin
          wr_cmd_d  = 1'b1;
          wr_data_d = w_data_g;
          pend_d    = 1'b1;
        end else if (w_rd_g) begin
          rd_cmd_d  = 1'b1;
          pend_d    = 1'b1;
        end
        if (!w_req_g) begin
          state_d = ST_DRAIN;
        end else if (timer_q == C_TMR_LAST) begin
          state_d      = ST_DRAIN;
          timeout_d    = 1'b1;
          timeout_ch_d = gidx_q;
          blocked_d    = blocked_d | grant_q;
        end
      end
      ST_DRAIN: begin
        if (!pend_q && !spi_busy_i) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = '1;
    if (state_q == ST_GRANT) begin
      busy_o = ~grant_q | {NUM_CH{spi_busy_i | pend_q | w_cmd_out}};
    end
    dev_cs_n_o = ~grant_q | {NUM_CH{spi_ncs_i}};
  end

  assign grant_o       = grant_q;
  assign spi_wr_cmd_o  = wr_cmd_q;
  assign spi_rd_cmd_o  = rd_cmd_q;
  assign spi_wr_data_o = wr_data_q;
  assign rd_data_o     = spi_rd_data_i;
  assign timeout_o     = timeout_q;
  assign timeout_ch_o  = timeout_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_cfg_arbiter
// Purpose: Directed self-checking bench for spi_cfg_arbiter with a small
//          spi_master model and a write-data scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_cfg_arbiter;

  localparam int NUM_CH      = 3;
  localparam int MOSI_W      = 24;
  localparam int MISO_W      = 8;
  localparam int TIMEOUT_CYC = 64;

  logic                     clk_20m = 1'b0;
  logic                     rstn = 1'b0;
  logic [NUM_CH-1:0]        req_i = '0;
  logic [NUM_CH-1:0]        wr_cmd_i = '0;
  logic [NUM_CH-1:0]        rd_cmd_i = '0;
  logic [NUM_CH*MOSI_W-1:0] wr_data_i = '0;
  logic [NUM_CH-1:0]        busy_o;
  logic [MISO_W:0]          rd_data_o;
  logic [NUM_CH-1:0]        grant_o;
  logic                     spi_wr_cmd_o;
  logic                     spi_rd_cmd_o;
  logic [MOSI_W-1:0]        spi_wr_data_o;
  logic                     spi_busy_i = 1'b0;
  logic                     spi_ncs_i = 1'b1;
  logic [MISO_W:0]          spi_rd_data_i = 9'h0A5;
  logic [NUM_CH-1:0]        dev_cs_n_o;
  logic                     timeout_clr_i = 1'b0;
  logic                     timeout_o;
  logic [2:0]               timeout_ch_o;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  int          spi_len = 6;
  int          spi_cnt = 0;

  spi_cfg_arbiter #(
    .NUM_CH      (NUM_CH),
    .MOSI_W      (MOSI_W),
    .MISO_W      (MISO_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_20m       (clk_20m),
    .rstn          (rstn),
    .req_i         (req_i),
    .wr_cmd_i      (wr_cmd_i),
    .rd_cmd_i      (rd_cmd_i),
    .wr_data_i     (wr_data_i),
    .busy_o        (busy_o),
    .rd_data_o     (rd_data_o),
    .grant_o       (grant_o),
    .spi_wr_cmd_o  (spi_wr_cmd_o),
    .spi_rd_cmd_o  (spi_rd_cmd_o),
    .spi_wr_data_o (spi_wr_data_o),
    .spi_busy_i    (spi_busy_i),
    .spi_ncs_i     (spi_ncs_i),
    .spi_rd_data_i (spi_rd_data_i),
    .dev_cs_n_o    (dev_cs_n_o),
    .timeout_clr_i (timeout_clr_i),
    .timeout_o     (timeout_o),
    .timeout_ch_o  (timeout_ch_o)
  );

  always #25 clk_20m = ~clk_20m;

  // spi_master model: a command starts a spi_len-cycle transfer, ncs low while busy
  always @(posedge clk_20m) begin
    #1;
    if (!rstn) spi_cnt = 0;
    else if (spi_wr_cmd_o || spi_rd_cmd_o) spi_cnt = spi_len;
    else if (spi_cnt != 0) spi_cnt = spi_cnt - 1;
    spi_busy_i = (spi_cnt != 0);
    spi_ncs_i  = ~spi_busy_i;
  end

  // Scoreboard: every forwarded write must match the oldest expected word
  always @(negedge clk_20m) begin : sb_mon
    logic [23:0] e;
    if (rstn && spi_wr_cmd_o) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_wr: observed data=%06h expected no write", spi_wr_data_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (spi_wr_data_o === e) else begin
          errors++;
          $error("FAIL sb_wr_data: observed=%06h expected=%06h", spi_wr_data_o, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_20m);
    #10;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int ch, input logic [23:0] d);
    wr_data_i[ch*MOSI_W +: MOSI_W] = d;
    wr_cmd_i[ch] = 1'b1;
    exp_q.push_back(d);
    tick();
    wr_cmd_i = '0;
  endtask

  task automatic wait_grant(input string tag, input logic [2:0] exp);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant_o != 3'b000) break;
    end
    check(tag, 32'(grant_o), 32'(exp));
  endtask

  task automatic wait_zero(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (grant_o == 3'b000) break;
      tick();
    end
    check(tag, 32'(grant_o), 32'd0);
  endtask

  task automatic wait_busy_low(input string tag, input int ch);
    for (int i = 0; i < 60; i++) begin
      if (busy_o[ch] == 1'b0) break;
      tick();
    end
    check(tag, 32'(busy_o[ch]), 32'd0);
  endtask

  initial begin
    // Reset
    tick(); tick(); tick();
    check("rst_grant",   32'(grant_o),      32'd0);
    check("rst_busy",    32'(busy_o),       32'h7);
    check("rst_cs",      32'(dev_cs_n_o),   32'h7);
    check("rst_wr_cmd",  32'(spi_wr_cmd_o), 32'd0);
    check("rst_rd_cmd",  32'(spi_rd_cmd_o), 32'd0);
    check("rst_wr_data", 32'(spi_wr_data_o), 32'd0);
    check("rst_timeout", 32'(timeout_o),    32'd0);
    check("rst_to_ch",   32'(timeout_ch_o), 32'd0);
    check("rd_data_a5",  32'(rd_data_o),    32'h0A5);
    spi_rd_data_i = 9'h15A;
    #1;
    check("rd_data_15a", 32'(rd_data_o),    32'h15A);
    rstn = 1'b1;
    tick();

    // T2: round robin from reset pointer (NUM_CH-1) -> 0,1,2, then again 0,1,2
    for (int r = 0; r < 2; r++) begin
      req_i = 3'b111;
      for (int e = 0; e < 3; e++) begin
        wait_grant("rr_grant", 3'(1 << e));
        do_write(e, 24'h100000 + 24'(r * 16 + e));
        wait_busy_low("rr_busy_low", e);
        req_i[e] = 1'b0;
        wait_zero("rr_release");
      end
    end

    // T1: single channel write
    req_i = 3'b010;
    tick();
    check("t1_grant", 32'(grant_o), 32'h2);
    check("t1_busy_idle", 32'(busy_o), 32'h5);
    do_write(1, 24'h000F5A);
    check("t1_wr_cmd", 32'(spi_wr_cmd_o), 32'd1);
    check("t1_cs", 32'(dev_cs_n_o), 32'h5);
    check("t1_busy", 32'(busy_o), 32'h7);
    wait_busy_low("t1_busy_low", 1);
    check("t1_cs_idle", 32'(dev_cs_n_o), 32'h7);
    req_i = 3'b000;
    wait_zero("t1_release");

    // T3: contention and strobe filtering
    req_i = 3'b001;
    wait_grant("t3_grant", 3'b001);
    wr_data_i[2*MOSI_W +: MOSI_W] = 24'hDEAD00;
    wr_cmd_i[2] = 1'b1;
    tick();
    wr_cmd_i = '0;
    check("t3_no_fwd", 32'(spi_wr_cmd_o), 32'd0);
    check("t3_busy2",  32'(busy_o[2]),    32'd1);
    check("t3_cs2",    32'(dev_cs_n_o[2]), 32'd1);
    wr_data_i[0 +: MOSI_W] = 24'h123456;
    wr_cmd_i[0] = 1'b1;
    rd_cmd_i[0] = 1'b1;
    exp_q.push_back(24'h123456);
    tick();
    wr_cmd_i = '0;
    rd_cmd_i = '0;
    check("t3_wr_wins", 32'(spi_wr_cmd_o), 32'd1);
    check("t3_rd_drop", 32'(spi_rd_cmd_o), 32'd0);
    check("t3_busy2b",  32'(busy_o[2]),    32'd1);
    check("t3_cs2b",    32'(dev_cs_n_o[2]), 32'd1);
    wait_busy_low("t3_busy_low_a", 0);
    rd_cmd_i[0] = 1'b1;
    tick();
    rd_cmd_i = '0;
    check("t3_rd_fwd", 32'(spi_rd_cmd_o), 32'd1);
    check("t3_rd_nowr", 32'(spi_wr_cmd_o), 32'd0);
    wait_busy_low("t3_busy_low_b", 0);
    req_i = 3'b000;
    wait_zero("t3_release");
    wr_cmd_i[0] = 1'b1;
    tick();
    wr_cmd_i = '0;
    check("t3_idle_drop", 32'(spi_wr_cmd_o), 32'd0);

    // T4: request dropped mid-transfer
    spi_len = 20;
    req_i = 3'b010;
    wait_grant("t4_grant", 3'b010);
    do_write(1, 24'hA5A5A5);
    tick();
    req_i = 3'b000;
    tick();
    check("t4_grant_hold", 32'(grant_o), 32'h2);
    check("t4_cs_routed", 32'(dev_cs_n_o), 32'h5);
    check("t4_busy_all",  32'(busy_o), 32'h7);
    wait_zero("t4_release");
    check("t4_spi_idle", 32'(spi_busy_i), 32'd0);
    spi_len = 6;

    // T5: timeout
    req_i = 3'b001;
    wait_grant("t5_grant0", 3'b001);
    begin
      int n;
      n = 0;
      for (int i = 0; i < 200; i++) begin
        tick();
        n++;
        if (timeout_o) break;
      end
      check("t5_cycles", 32'(n), 32'd64);
    end
    check("t5_flag",  32'(timeout_o),    32'd1);
    check("t5_ch",    32'(timeout_ch_o), 32'd0);
    req_i = 3'b011;
    wait_grant("t5_grant1", 3'b010);
    req_i = 3'b001;
    wait_zero("t5_release1");
    for (int i = 0; i < 5; i++) tick();
    check("t5_blocked", 32'(grant_o), 32'd0);
    check("t5_sticky",  32'(timeout_o), 32'd1);
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    check("t5_clr", 32'(timeout_o), 32'd0);
    req_i = 3'b000;
    tick();
    req_i = 3'b001;
    wait_grant("t5_regrant0", 3'b001);
    req_i = 3'b000;
    wait_zero("t5_release0");

    // T6: reset mid-grant
    req_i = 3'b100;
    wait_grant("t6_grant", 3'b100);
    rstn = 1'b0;
    tick();
    check("t6_grant", 32'(grant_o), 32'd0);
    check("t6_busy",  32'(busy_o),  32'h7);
    check("t6_cs",    32'(dev_cs_n_o), 32'h7);
    check("t6_wr",    32'(spi_wr_cmd_o), 32'd0);
    rstn = 1'b1;
    wait_grant("t6_regrant", 3'b100);
    req_i = 3'b000;
    wait_zero("t6_release");

    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
